// File: rtl/prog_intr_handler_pkg.sv
// prog_intr_handler_pkg: SPR numbers, ESR bit masks and MSR keep-mask for program interrupts
package prog_intr_handler_pkg;
    localparam logic [9:0]  SPRN_SRR0 = 10'd26;
    localparam logic [9:0]  SPRN_SRR1 = 10'd27;
    localparam logic [9:0]  SPRN_ESR  = 10'd62;
    localparam logic [31:0] ESR_PIL   = 32'h0800_0000;
    localparam logic [31:0] ESR_PPR   = 32'h0400_0000;
    localparam logic [31:0] ESR_PTR   = 32'h0200_0000;
    localparam logic [31:0] MSR_KEEP  = 32'h0002_1200;
endpackage

// File: rtl/prog_esr_encode.sv
// prog_esr_encode: priority-encodes {illegal, privilege, trap} into a one-hot ESR value
module prog_esr_encode
    import prog_intr_handler_pkg::*;
(
    input  logic [2:0]  code,
    output logic [31:0] esr
);
    always_comb begin
        esr = code[2] ? ESR_PIL : code[1] ? ESR_PPR : code[0] ? ESR_PTR : '0;
    end
endmodule

// File: rtl/prog_intr_handler.sv
// prog_intr_handler: saves SRR0/SRR1/ESR, redirects to the program vector and acks the detector
module prog_intr_handler
    import prog_intr_handler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        progErr,
    input  logic [2:0]  progErrCode,
    input  logic [31:0] excPC,
    input  logic [31:0] MSR,
    input  logic [31:0] IVPR,
    input  logic [31:0] IVOR6,
    input  logic        stall,
    output logic        ack,
    output logic        sprWr,
    output logic [9:0]  sprWrAddr,
    output logic [31:0] sprWrData,
    output logic        msrWr,
    output logic [31:0] msrWrData,
    output logic        npcWr,
    output logic [31:0] npcData,
    output logic        flush,
    output logic [15:0] intrCnt
);
    typedef enum logic [2:0] {IDLE, SAVE_SRR0, SAVE_SRR1, SAVE_ESR, REDIRECT, ACK} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, msr_q, msr_d, esr;
    logic [2:0]  code_q, code_d;
    logic [15:0] intr_cnt_q, intr_cnt_d;
    logic        go;
    logic        unused_bits;

    assign unused_bits = ^{IVPR[15:0], IVOR6[31:16], IVOR6[3:0]};

    prog_esr_encode u_esr (.code(code_q), .esr(esr));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        msr_d      = msr_q;
        code_d     = code_q;
        intr_cnt_d = intr_cnt_q;
        if (!stall) begin
            case (state_q)
                IDLE: if (progErr) begin
                    state_d = SAVE_SRR0;
                    pc_d    = excPC;
                    msr_d   = MSR;
                    code_d  = progErrCode;
                end
                SAVE_SRR0: state_d = SAVE_SRR1;
                SAVE_SRR1: state_d = SAVE_ESR;
                SAVE_ESR:  state_d = REDIRECT;
                REDIRECT:  state_d = ACK;
                ACK: begin
                    state_d    = IDLE;
                    intr_cnt_d = intr_cnt_q + {15'd0, ~&intr_cnt_q};
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            msr_q      <= '0;
            code_q     <= '0;
            intr_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            msr_q      <= msr_d;
            code_q     <= code_d;
            intr_cnt_q <= intr_cnt_d;
        end
    end

    // Strobes are masked by rst as well so an abort suppresses the write in the reset cycle itself
    always_comb begin
        go        = !stall && !rst;
        sprWr     = go && (state_q == SAVE_SRR0 || state_q == SAVE_SRR1 || state_q == SAVE_ESR);
        sprWrAddr = !sprWr ? '0 : state_q == SAVE_SRR0 ? SPRN_SRR0 : state_q == SAVE_SRR1 ? SPRN_SRR1 : SPRN_ESR;
        sprWrData = !sprWr ? '0 : state_q == SAVE_SRR0 ? pc_q : state_q == SAVE_SRR1 ? msr_q : esr;
        msrWr     = go && state_q == REDIRECT;
        msrWrData = msrWr ? (msr_q & MSR_KEEP) : '0;
        npcWr     = msrWr;
        npcData   = npcWr ? {IVPR[31:16], IVOR6[15:4], 4'b0} : '0;
        ack       = go && state_q == ACK;
        flush     = state_q != IDLE;
        intrCnt   = intr_cnt_q;
    end
endmodule
